// File: rtl/morse_encoder.sv
// morse_encoder: turns accepted ASCII characters into a keyed Morse signal
// with exact unit timing, reporting completion (done) or rejection (err).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | key low, char_ready high, waiting for a character
// MARK  | key high for one element: 1 unit (dot) or 3 units (dash)
// EGAP  | key low for 1 unit between elements of the same character
// LGAP  | key low for 3 units after the last element, then done
// WGAP  | key low for 4 units for a space, then done
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Wide enough for the longest load value (4*UNIT_CYCLES - 1).
    localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
    localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LD = CW'(4 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MARK, EGAP, LGAP, WGAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    rem;
    logic [4:0]    sh;

    logic [7:0]    up;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic [4:0]    rom_aligned;
    logic          is_space;

    // Case folding and code ROM; pattern is right-aligned, MSB-first in len,
    // then left-aligned so the current element always sits in bit 4.
    always_comb begin
        up = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7A) up = char_in - 8'h20;
        rom_len = 3'd0;
        rom_pat = 5'b00000;
        case (up)
            8'h41: {rom_len, rom_pat} = {3'd2, 5'b00001}; // A .-
            8'h42: {rom_len, rom_pat} = {3'd4, 5'b01000}; // B -...
            8'h43: {rom_len, rom_pat} = {3'd4, 5'b01010}; // C -.-.
            8'h44: {rom_len, rom_pat} = {3'd3, 5'b00100}; // D -..
            8'h45: {rom_len, rom_pat} = {3'd1, 5'b00000}; // E .
            8'h46: {rom_len, rom_pat} = {3'd4, 5'b00010}; // F ..-.
            8'h47: {rom_len, rom_pat} = {3'd3, 5'b00110}; // G --.
            8'h48: {rom_len, rom_pat} = {3'd4, 5'b00000}; // H ....
            8'h49: {rom_len, rom_pat} = {3'd2, 5'b00000}; // I ..
            8'h4A: {rom_len, rom_pat} = {3'd4, 5'b00111}; // J .---
            8'h4B: {rom_len, rom_pat} = {3'd3, 5'b00101}; // K -.-
            8'h4C: {rom_len, rom_pat} = {3'd4, 5'b00100}; // L .-..
            8'h4D: {rom_len, rom_pat} = {3'd2, 5'b00011}; // M --
            8'h4E: {rom_len, rom_pat} = {3'd2, 5'b00010}; // N -.
            8'h4F: {rom_len, rom_pat} = {3'd3, 5'b00111}; // O ---
            8'h50: {rom_len, rom_pat} = {3'd4, 5'b00110}; // P .--.
            8'h51: {rom_len, rom_pat} = {3'd4, 5'b01101}; // Q --.-
            8'h52: {rom_len, rom_pat} = {3'd3, 5'b00010}; // R .-.
            8'h53: {rom_len, rom_pat} = {3'd3, 5'b00000}; // S ...
            8'h54: {rom_len, rom_pat} = {3'd1, 5'b00001}; // T -
            8'h55: {rom_len, rom_pat} = {3'd3, 5'b00001}; // U ..-
            8'h56: {rom_len, rom_pat} = {3'd4, 5'b00001}; // V ...-
            8'h57: {rom_len, rom_pat} = {3'd3, 5'b00011}; // W .--
            8'h58: {rom_len, rom_pat} = {3'd4, 5'b01001}; // X -..-
            8'h59: {rom_len, rom_pat} = {3'd4, 5'b01011}; // Y -.--
            8'h5A: {rom_len, rom_pat} = {3'd4, 5'b01100}; // Z --..
            8'h30: {rom_len, rom_pat} = {3'd5, 5'b11111}; // 0
            8'h31: {rom_len, rom_pat} = {3'd5, 5'b01111}; // 1
            8'h32: {rom_len, rom_pat} = {3'd5, 5'b00111}; // 2
            8'h33: {rom_len, rom_pat} = {3'd5, 5'b00011}; // 3
            8'h34: {rom_len, rom_pat} = {3'd5, 5'b00001}; // 4
            8'h35: {rom_len, rom_pat} = {3'd5, 5'b00000}; // 5
            8'h36: {rom_len, rom_pat} = {3'd5, 5'b10000}; // 6
            8'h37: {rom_len, rom_pat} = {3'd5, 5'b11000}; // 7
            8'h38: {rom_len, rom_pat} = {3'd5, 5'b11100}; // 8
            8'h39: {rom_len, rom_pat} = {3'd5, 5'b11110}; // 9
            default: {rom_len, rom_pat} = {3'd0, 5'b00000};
        endcase
        rom_aligned = rom_pat << (3'd5 - rom_len);
        is_space    = (char_in == 8'h20);
    end

    assign char_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // Sequencer: duration down-counter reloads on every state entry and the
    // state advances on its terminal count of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= 3'd0;
            sh    <= 5'b00000;
            key   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        if (rom_len != 3'd0) begin
                            state <= MARK;
                            key   <= 1'b1;
                            rem   <= rom_len;
                            sh    <= rom_aligned;
                            cnt   <= rom_aligned[4] ? DASH_LD : DOT_LD;
                        end else if (is_space) begin
                            state <= WGAP;
                            cnt   <= WORD_LD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (cnt == '0) begin
                        key <= 1'b0;
                        if (rem > 3'd1) begin
                            state <= EGAP;
                            cnt   <= DOT_LD;
                        end else begin
                            state <= LGAP;
                            cnt   <= DASH_LD;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EGAP: begin
                    if (cnt == '0) begin
                        state <= MARK;
                        key   <= 1'b1;
                        rem   <= rem - 3'd1;
                        sh    <= sh << 1;
                        cnt   <= sh[3] ? DASH_LD : DOT_LD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                LGAP, WGAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: drives character streams into two encoders (4-cycle and
// 1-cycle units) and compares every output cycle with a dot/dash string model.
module tb_morse_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in0, char_in1;
    logic       char_valid0, char_valid1;
    logic       char_ready0, key0, busy0, done0, err0;
    logic       char_ready1, key1, busy1, done1, err1;

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .char_in(char_in0), .char_valid(char_valid0),
        .char_ready(char_ready0), .key(key0), .busy(busy0), .done(done0), .err(err0)
    );

    morse_encoder #(.UNIT_CYCLES(1)) dut_u1 (
        .clk(clk), .reset(reset), .char_in(char_in1), .char_valid(char_valid1),
        .char_ready(char_ready1), .key(key1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                            "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                            "-.--", "--.."};
    string digits [10] = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----."};

    logic [7:0] stim[$];
    logic [4:0] exp_q[$];   // per cycle {key, done, err, busy, char_ready}
    logic [4:0] trace[$];

    function automatic logic [4:0] obs(input bit sel);
        return sel ? {key1, done1, err1, busy1, char_ready1}
                   : {key0, done0, err0, busy0, char_ready0};
    endfunction

    function automatic string code_of(input logic [7:0] ch);
        int c;
        c = int'(ch);
        if (c >= 97 && c <= 122) c = c - 32;
        if (c >= 65 && c <= 90) return letters[c - 65];
        if (c >= 48 && c <= 57) return digits[c - 48];
        return "";
    endfunction

    task automatic load(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Expected trace, starting with the cycle after the first accept edge.
    task automatic build_model(input int u, input int tail);
        logic [7:0] c;
        string code;
        exp_q.delete();
        for (int k = 0; k < stim.size(); k++) begin
            c = stim[k];
            if (c == 8'h20) begin
                repeat (4 * u) exp_q.push_back(5'b00010);
                exp_q.push_back(5'b01001);
            end else begin
                code = code_of(c);
                if (code.len() == 0) begin
                    exp_q.push_back(5'b00101);
                end else begin
                    for (int i = 0; i < code.len(); i++) begin
                        repeat ((code[i] == 8'h2D) ? 3 * u : u) exp_q.push_back(5'b10010);
                        if (i < code.len() - 1) repeat (u) exp_q.push_back(5'b00010);
                    end
                    repeat (3 * u) exp_q.push_back(5'b00010);
                    exp_q.push_back(5'b01001);
                end
            end
        end
        repeat (tail) exp_q.push_back(5'b00001);
    endtask

    // Presents stim with char_valid held high, records exp_q.size() cycles.
    task automatic run_stream(input bit sel);
        int  idx;
        bit  v, acc;
        idx = 0;
        trace.delete();
        for (int cyc = 0; cyc < exp_q.size(); cyc++) begin
            v = (idx < stim.size());
            if (sel) begin
                char_valid1 = v;
                char_in1    = v ? stim[idx] : 8'h00;
                acc         = v && char_ready1;
            end else begin
                char_valid0 = v;
                char_in0    = v ? stim[idx] : 8'h00;
                acc         = v && char_ready0;
            end
            @(posedge clk);
            #1;
            trace.push_back(obs(sel));
            if (acc) idx++;
        end
        char_valid0 = 1'b0;
        char_valid1 = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (key0 !== 1'b0) begin failures++; $display("FAIL reset_key got=%b exp=0", key0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err0); end
        checks++; if (char_ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", char_ready0); end
        checks++; if (char_ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready_u1 got=%b exp=1", char_ready1); end
    endtask

    task automatic test_single_a;
        int ones;
        load("A");
        build_model(4, 3);
        run_stream(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_a cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
        checks++;
        if (trace[32] !== 5'b01001) begin
            failures++;
            $display("FAIL single_a_done_at_32 got=%b exp=01001", trace[32]);
        end
        ones = 0;
        for (int i = 0; i < trace.size(); i++) ones += int'(trace[i][4]);
        checks++;
        if (ones != 16) begin failures++; $display("FAIL single_a_key_cycles got=%0d exp=16", ones); end
    endtask

    task automatic test_back_to_back;
        int dones;
        load("ET0");
        build_model(4, 2);
        run_stream(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
        dones = 0;
        for (int i = 0; i < trace.size(); i++) dones += int'(trace[i][3]);
        checks++;
        if (dones != 3) begin failures++; $display("FAIL back_to_back_dones got=%0d exp=3", dones); end
    endtask

    task automatic test_word_case;
        int second;
        load("e e");
        build_model(4, 2);
        run_stream(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL word_case cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
        second = -1;
        for (int i = 5; i < trace.size(); i++)
            if (second < 0 && trace[i][4] === 1'b1) second = i;
        // mark 4 + letter gap 12 + done cycle 1 + word gap 16 + done cycle 1
        checks++;
        if (second != 34) begin failures++; $display("FAIL word_case_second_mark got=%0d exp=34", second); end
    endtask

    task automatic test_unsupported;
        load("#T");
        build_model(4, 2);
        run_stream(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL unsupported cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
        checks++;
        if (trace[0] !== 5'b00101) begin failures++; $display("FAIL unsupported_err got=%b exp=00101", trace[0]); end
    endtask

    task automatic test_reset_mid;
        char_in0 = 8'h4F;
        char_valid0 = 1'b1;
        @(posedge clk);
        #1;
        char_valid0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (key0 !== 1'b1) begin failures++; $display("FAIL reset_mid_in_dash got=%b exp=1", key0); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (key0 !== 1'b0) begin failures++; $display("FAIL reset_mid_key got=%b exp=0", key0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy0); end
        checks++; if (char_ready0 !== 1'b1) begin failures++; $display("FAIL reset_mid_ready got=%b exp=1", char_ready0); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        load("S");
        build_model(4, 2);
        run_stream(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_mid_s cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_unit1;
        load("R5 #QT");
        build_model(1, 2);
        run_stream(1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (trace[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL unit1 cyc=%0d kdebr got=%b exp=%b", i, trace[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        string pool;
        bit    sel;
        pool = "ABCHJQXYZ0159aqwz #?%@";
        for (int r = 0; r < 8; r++) begin
            sel = (r >= 5);
            stim.delete();
            for (int n = 0; n < 6; n++) stim.push_back(pool[$urandom_range(pool.len() - 1, 0)]);
            build_model(sel ? 1 : 4, 2);
            run_stream(sel);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (trace[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random r=%0d u=%0d cyc=%0d kdebr got=%b exp=%b",
                             r, sel ? 1 : 4, i, trace[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        char_in0    = 8'h00;
        char_in1    = 8'h00;
        char_valid0 = 1'b0;
        char_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_single_a;
        test_back_to_back;
        test_word_case;
        test_unsupported;
        test_reset_mid;
        test_unit1;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
